// File: rtl/udp_frame_tx.sv
// udp_frame_tx: reads one released half of the ping-pong pre-buffer RAM and
// streams it as a framed packet of 16-bit words: {seq, len, payload[0..len-1]}.
// Ports:
//   clk, nRST               clock, asynchronous active-low reset
//   udp_start               start request (rising edge detected)
//   ping_pong, length       writer bank bit and payload length, sampled at start
//   ram_rden, ram_rdaddr    RAM read request {bank, index}
//   ram_q                   RAM read data, RAM_LAT cycles after ram_rden
//   tx_data/valid/ready     output stream with tx_sop on header word 0,
//   tx_sop, tx_eop          tx_eop on the last payload word
//   udp_busy                bank interlock back to the writer, covers the gap
//   err                     sticky: bad length or start while not idle
module udp_frame_tx #(
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned GAP     = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        udp_start,
  input  logic        ping_pong,
  input  logic [15:0] length,
  output logic        ram_rden,
  output logic [10:0] ram_rdaddr,
  input  logic [15:0] ram_q,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        udp_busy,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 10;
  localparam int unsigned LW = 11;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 2;
  localparam int unsigned PL = RAM_LAT;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam bit          NO_GAP = (GAP == 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]    state, state_d;
  logic          start_q;
  logic          bank, bank_d;
  logic [LW-1:0] len, len_d;
  logic [DW-1:0] seq, seq_d;
  logic [LW-1:0] rd_cnt, rd_cnt_d;
  logic [LW-1:0] ld_cnt, ld_cnt_d;
  logic [CW-1:0] credit, credit_d;
  logic [PL-1:0] rd_pipe, rd_pipe_d;
  logic [CW-1:0] fifo_cnt, fifo_cnt_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [DW-1:0] fifo_mem [FD];

  logic          ram_rden_d;
  logic [10:0]   ram_rdaddr_d;
  logic [DW-1:0] tx_data_d;
  logic          tx_valid_d, tx_sop_d, tx_eop_d, udp_busy_d, err_d;

  logic          rise, q_valid, fifo_empty, src_avail, accept, out_free;
  logic          in_frame, issue, pay_load, push, pop, len_ok;
  logic [DW-1:0] src_data;

  // Datapath qualifiers: a payload word comes from the FIFO head, or straight
  // from ram_q when the FIFO is empty (bypass keeps reads back-to-back).
  always_comb begin
    rise       = udp_start & ~start_q;
    q_valid    = rd_pipe[PL-1];
    fifo_empty = (fifo_cnt == '0);
    src_avail  = ~fifo_empty | q_valid;
    src_data   = fifo_empty ? ram_q : fifo_mem[rd_ptr];
    accept     = tx_valid & tx_ready;
    out_free   = ~tx_valid | tx_ready;
    in_frame   = (state == S_HDR0) | (state == S_HDR1) | (state == S_PAY);
    // credit counts words issued but not yet moved to the output register
    issue      = in_frame & (rd_cnt < len) & (credit < CW'(FD));
    pay_load   = src_avail & (((state == S_HDR1) & accept) |
                              ((state == S_PAY) & out_free & ~(accept & tx_eop)));
    pop        = pay_load & ~fifo_empty;
    push       = q_valid & ~(pay_load & fifo_empty);
    len_ok     = (length != '0) && (length <= 16'(MAX_LEN));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    bank_d       = bank;
    len_d        = len;
    seq_d        = seq;
    rd_cnt_d     = rd_cnt;
    ld_cnt_d     = ld_cnt;
    gap_cnt_d    = gap_cnt;
    ram_rden_d   = issue;
    ram_rdaddr_d = ram_rdaddr;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    tx_sop_d     = tx_sop;
    tx_eop_d     = tx_eop;
    udp_busy_d   = udp_busy;
    err_d        = err;
    rd_pipe_d    = PL'({rd_pipe, ram_rden});

    credit_d = credit;
    case ({issue, pay_load})
      2'b10:   credit_d = credit + CW'(1);
      2'b01:   credit_d = credit - CW'(1);
      default: credit_d = credit;
    endcase

    fifo_cnt_d = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt - CW'(1);
      default: fifo_cnt_d = fifo_cnt;
    endcase
    wr_ptr_d = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_d = pop  ? rd_ptr + PW'(1) : rd_ptr;

    if (issue) begin
      rd_cnt_d     = rd_cnt + LW'(1);
      ram_rdaddr_d = {bank, rd_cnt[IW-1:0]};
    end

    if (pay_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = src_data;
      tx_sop_d   = 1'b0;
      tx_eop_d   = (ld_cnt == len - LW'(1));
      ld_cnt_d   = ld_cnt + LW'(1);
    end

    case (state)
      S_IDLE: begin
        if (rise) begin
          if (len_ok) begin
            bank_d     = ~ping_pong;
            len_d      = length[LW-1:0];
            rd_cnt_d   = '0;
            ld_cnt_d   = '0;
            udp_busy_d = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = seq;
            tx_sop_d   = 1'b1;
            tx_eop_d   = 1'b0;
            state_d    = S_HDR0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HDR0: begin
        if (accept) begin
          tx_data_d = DW'(len);
          tx_sop_d  = 1'b0;
          state_d   = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          state_d = S_PAY;
          if (!pay_load) tx_valid_d = 1'b0;
        end
      end
      S_PAY: begin
        if (accept && tx_eop) begin
          tx_valid_d = 1'b0;
          tx_eop_d   = 1'b0;
          seq_d      = seq + DW'(1);
          gap_cnt_d  = '0;
          if (NO_GAP) begin
            udp_busy_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else if (out_free && !pay_load) begin
          tx_valid_d = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          udp_busy_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rise && (state != S_IDLE)) err_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      bank       <= 1'b0;
      len        <= '0;
      seq        <= '0;
      rd_cnt     <= '0;
      ld_cnt     <= '0;
      credit     <= '0;
      rd_pipe    <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      ram_rden   <= 1'b0;
      ram_rdaddr <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_sop     <= 1'b0;
      tx_eop     <= 1'b0;
      udp_busy   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      start_q    <= udp_start;
      bank       <= bank_d;
      len        <= len_d;
      seq        <= seq_d;
      rd_cnt     <= rd_cnt_d;
      ld_cnt     <= ld_cnt_d;
      credit     <= credit_d;
      rd_pipe    <= rd_pipe_d;
      fifo_cnt   <= fifo_cnt_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      gap_cnt    <= gap_cnt_d;
      ram_rden   <= ram_rden_d;
      ram_rdaddr <= ram_rdaddr_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      tx_sop     <= tx_sop_d;
      tx_eop     <= tx_eop_d;
      udp_busy   <= udp_busy_d;
      err        <= err_d;
    end
  end

  // Prefetch storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_q;
  end

endmodule

// File: tb/tb_udp_frame_tx.sv
// tb_udp_frame_tx: randomized scoreboard bench for udp_frame_tx. Expected
// words are queued at start time from a memory-level model; a monitor pops and
// compares on every accepted transfer.
module tb_udp_frame_tx;

  localparam int unsigned RAM_LAT = 2;
  localparam int unsigned MAX_LEN = 1024;
  localparam int unsigned GAP     = 4;

  logic        clk, nRST, udp_start, ping_pong, tx_ready;
  logic [15:0] length, ram_q, tx_data;
  logic        ram_rden, tx_valid, tx_sop, tx_eop, udp_busy, err;
  logic [10:0] ram_rdaddr;

  udp_frame_tx #(.RAM_LAT(RAM_LAT), .MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk(clk), .nRST(nRST), .udp_start(udp_start), .ping_pong(ping_pong),
    .length(length), .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_q(ram_q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop),
    .tx_eop(tx_eop), .udp_busy(udp_busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // RAM model with RAM_LAT-cycle read pipeline and a log of every read address
  logic [15:0] mem [0:2047];
  logic [15:0] qpipe [0:2];
  logic [10:0] rd_log [$];
  always @(posedge clk) begin
    if (ram_rden) rd_log.push_back(ram_rdaddr);
    qpipe[0] <= ram_rden ? mem[ram_rdaddr] : 16'hDEAD;
    qpipe[1] <= qpipe[0];
    qpipe[2] <= qpipe[1];
  end
  assign ram_q = qpipe[RAM_LAT-1];

  // Reference model state
  logic [17:0] exp_q [$];   // {data, sop, eop}
  logic [15:0] m_seq;
  logic        m_err;
  int          cur_len;
  int          rd_base;
  bit          rdy_mode;    // 0: tx_ready held high, 1: random

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop, hold stability, busy/gap timing, throughput
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          sop_cyc = 0, eop_cyc = 0;
  bit          eop_seen = 0, have_prev = 0;
  logic        p_valid, p_ready, p_sop, p_eop, p_busy;
  logic [15:0] p_data;
  always @(negedge clk) begin
    logic [17:0] item;
    cyc++;
    if (!nRST) begin
      have_prev = 0;
      eop_seen  = 0;
    end else begin
      if (have_prev && p_valid && !p_ready)
        check("hold", {13'b0, tx_valid, tx_data, tx_sop, tx_eop}, {13'b0, 1'b1, p_data, p_sop, p_eop});
      if (tx_valid) check("valid_in_busy", {31'b0, udp_busy}, 32'd1);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'b0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          item = exp_q.pop_front();
          check("tx_word", {14'b0, tx_data, tx_sop, tx_eop}, {14'b0, item});
        end
        xfer_cnt++;
        if (tx_sop) sop_cyc = cyc;
        if (tx_eop) begin
          eop_cyc  = cyc;
          eop_seen = 1;
          if (!rdy_mode)
            check("throughput", {31'b0, (eop_cyc - sop_cyc) <= cur_len + 1 + int'(RAM_LAT)}, 32'd1);
        end
      end
      if (eop_seen && p_busy && !udp_busy) begin
        check("gap_len", cyc - eop_cyc, GAP + 1);
        eop_seen = 0;
      end
      have_prev = 1;
      p_valid = tx_valid; p_ready = tx_ready; p_sop = tx_sop;
      p_eop = tx_eop; p_data = tx_data; p_busy = udp_busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic pp, input int len);
    step();
    ping_pong = pp;
    length    = 16'(len);
    udp_start = 1'b1;
    step();
    udp_start = 1'b0;
  endtask

  // Queue the whole expected frame, then request it
  task automatic send_frame(input logic pp, input int len);
    if (len >= 1 && len <= int'(MAX_LEN)) begin
      exp_q.push_back({m_seq, 2'b10});
      exp_q.push_back({16'(len), 2'b00});
      for (int i = 0; i < len; i++) begin
        logic [10:0] a;
        a = {~pp, 10'(i)};
        exp_q.push_back({mem[a], 1'b0, (i == len - 1)});
      end
      m_seq = m_seq + 16'd1;
    end else begin
      m_err = 1'b1;
    end
    cur_len = len;
    rd_base = rd_log.size();
    pulse(pp, len);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (!udp_busy) begin ok = 1; break; end
      step();
    end
    check("idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_xfer(input int n);
    int base = xfer_cnt;
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      if (xfer_cnt - base >= n) begin ok = 1; break; end
      step();
    end
    check("xfer_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic finish_frame(input logic pp, input int len);
    int bad = 0;
    wait_idle(6000);
    check("frame_drain", exp_q.size(), 0);
    if (rd_log.size() - rd_base != len) bad++;
    else
      for (int i = 0; i < len; i++) begin
        logic [10:0] a;
        a = {~pp, 10'(i)};
        if (rd_log[rd_base + i] !== a) bad++;
      end
    check("rd_once_in_order", bad, 0);
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"}, {31'b0, tx_valid}, 0);
    check({tag, "_tx_sop"}, {31'b0, tx_sop}, 0);
    check({tag, "_tx_eop"}, {31'b0, tx_eop}, 0);
    check({tag, "_tx_data"}, {16'b0, tx_data}, 0);
    check({tag, "_ram_rden"}, {31'b0, ram_rden}, 0);
    check({tag, "_ram_rdaddr"}, {21'b0, ram_rdaddr}, 0);
    check({tag, "_udp_busy"}, {31'b0, udp_busy}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) step();
    exp_q.delete();
    m_seq = '0;
    m_err = 1'b0;
    nRST = 1'b1;
    step();
  endtask

  initial begin
    nRST = 1'b0; udp_start = 1'b0; ping_pong = 1'b0; length = '0;
    rdy_mode = 0; m_seq = '0; m_err = 1'b0; cur_len = 0; rd_base = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
    repeat (3) step();
    check_outputs_zero("reset");
    nRST = 1'b1;
    step();

    // T1: bank0 = 0x100..0x107, ready high
    send_frame(1'b1, 8);
    finish_frame(1'b1, 8);
    // T2: same frame under random backpressure; header now carries seq 1
    rdy_mode = 1;
    send_frame(1'b1, 8);
    finish_frame(1'b1, 8);
    // Random frames
    repeat (6) begin
      logic pp;
      int   len;
      pp  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      rdy_mode = 1'($urandom_range(0, 1));
      send_frame(pp, len);
      finish_frame(pp, len);
    end
    // T3: full half, bank1
    rdy_mode = 0;
    send_frame(1'b0, 1024);
    finish_frame(1'b0, 1024);
    // T4: illegal lengths
    send_frame(1'b1, 0);
    repeat (4) step();
    check("t4_busy_len0", {31'b0, udp_busy}, 0);
    check("t4_err_len0", {31'b0, err}, {31'b0, m_err});
    send_frame(1'b0, 1025);
    repeat (4) step();
    check("t4_busy_len1025", {31'b0, udp_busy}, 0);
    check("t4_err_len1025", {31'b0, err}, {31'b0, m_err});

    // T5: restart request during payload is ignored but flagged
    do_reset();
    check("t5_err_clear", {31'b0, err}, 0);
    send_frame(1'b1, 16);
    wait_xfer(4);
    pulse(1'b0, 5);
    m_err = 1'b1;
    finish_frame(1'b1, 16);

    // T6a: sequence wrap 0xFFFF -> 0x0000
    force dut.seq = 16'hFFFF;
    step();
    release dut.seq;
    step();
    m_seq = 16'hFFFF;
    send_frame(1'b0, 3);
    finish_frame(1'b0, 3);
    send_frame(1'b1, 2);
    finish_frame(1'b1, 2);

    // T6b: reset mid-payload, then a clean frame
    rdy_mode = 1;
    send_frame(1'b0, 40);
    wait_xfer(6);
    nRST = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    m_seq = '0;
    m_err = 1'b0;
    repeat (2) step();
    nRST = 1'b1;
    step();
    rdy_mode = 0;
    send_frame(1'b1, 8);
    finish_frame(1'b1, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
